prbs16_checker: RTL and testbench

Serial PRBS receiver and bit-error counter for the 16-bit XNOR LFSR sequence produced by the design's pseudo-random generator. It self-synchronises to an incoming bit stream, tracks lock, and counts mismatches against a locally regenerated sequence. It sits at the far end of the generator's serial output, typically on a loopback or an inter-board link. Optionally, it drives two seven-segment digits with the error count.

---
 rtl/prbs16_checker.sv | 154 +++++++++++++++
 tb/tb_prbs16_checker.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs16_checker.sv
// Self-synchronising receiver and bit-error counter for the 16-bit XNOR PRBS stream.
// Optional seven-segment display of the error count is built when PRBS_CHK_HEX_EN is defined.
module prbs16_checker #(
    parameter int LOCK_COUNT  = 32,
    parameter int LOSS_WINDOW = 64,
    parameter int LOSS_THRESH = 8,
    parameter int ERR_W       = 16
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic             sync_lost,
    output logic [ERR_W-1:0] err_count
`ifdef PRBS_CHK_HEX_EN
    ,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1
`endif
);
    localparam int MC_W = $clog2(LOCK_COUNT + 1);
    localparam int WP_W = $clog2(LOSS_WINDOW + 1);
    localparam int WE_W = $clog2(LOSS_THRESH + 1);

    // Handshake: a bit is consumed on every rising edge where bit_valid is high; there is no back-pressure.
    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    state_t           state, state_d;
    logic [15:0]      r, r_d;
    logic [4:0]       fill, fill_d;
    logic [MC_W-1:0]  match_cnt, match_cnt_d;
    logic [WP_W-1:0]  win_pos, win_pos_d;
    logic [WE_W-1:0]  win_err, win_err_d, win_err_inc;
    logic [ERR_W-1:0] err_count_d;
    logic             err_pulse_d, sync_lost_d;
    logic             fb, beat_ok, bit_err;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state     <= SEARCH;
            r         <= '0;
            fill      <= '0;
            match_cnt <= '0;
            win_pos   <= '0;
            win_err   <= '0;
            err_count <= '0;
            err_pulse <= 1'b0;
            sync_lost <= 1'b0;
        end else begin
            state     <= state_d;
            r         <= r_d;
            fill      <= fill_d;
            match_cnt <= match_cnt_d;
            win_pos   <= win_pos_d;
            win_err   <= win_err_d;
            err_count <= err_count_d;
            err_pulse <= err_pulse_d;
            sync_lost <= sync_lost_d;
        end
    end

    // The state register itself is the lock indicator, so locked is a registered output.
    assign locked = (state == LOCKED);

    always_comb begin
        fb          = ~(r[15] ^ r[14] ^ r[12] ^ r[3]);
        beat_ok     = (bit_in == fb) && (r != 16'hFFFF);
        bit_err     = (bit_in != fb);
        win_err_inc = win_err + WE_W'(bit_err);
        state_d     = state;
        r_d         = r;
        fill_d      = fill;
        match_cnt_d = match_cnt;
        win_pos_d   = win_pos;
        win_err_d   = win_err;
        err_count_d = err_count;
        err_pulse_d = 1'b0;
        sync_lost_d = 1'b0;
        if (bit_valid) begin
            case (state)
                SEARCH: begin
                    r_d = {r[14:0], bit_in};
                    if (fill != 5'd16) begin
                        fill_d = fill + 5'd1;
                    end else if (beat_ok) begin
                        match_cnt_d = match_cnt + MC_W'(1);
                        if (match_cnt == MC_W'(LOCK_COUNT - 1)) begin
                            state_d     = LOCKED;
                            match_cnt_d = '0;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: keep regenerating locally so bit errors never corrupt the reference.
                    r_d = {r[14:0], fb};
                    if (bit_err) begin
                        err_pulse_d = 1'b1;
                        if (err_count != '1) err_count_d = err_count + ERR_W'(1);
                    end
                    if (win_err_inc == WE_W'(LOSS_THRESH)) begin
                        state_d     = SEARCH;
                        sync_lost_d = 1'b1;
                        fill_d      = '0;
                        match_cnt_d = '0;
                        win_pos_d   = '0;
                        win_err_d   = '0;
                    end else if (win_pos == WP_W'(LOSS_WINDOW - 1)) begin
                        win_pos_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_pos_d = win_pos + WP_W'(1);
                        win_err_d = win_err_inc;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
        if (clr_cnt) err_count_d = '0;
    end

`ifdef PRBS_CHK_HEX_EN
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    // Narrow counters are zero-extended so HEX1 still shows a valid digit.
    logic [7:0] cnt8;
    assign cnt8 = 8'(err_count);
    assign HEX0 = seg7(cnt8[3:0]);
    assign HEX1 = seg7(cnt8[7:4]);
`endif
endmodule

// File: tb/tb_prbs16_checker.sv
// Bench for prbs16_checker: directed lock/loss/saturation sequences, a vector table and
// randomized traffic scored against a history-based model; a 4-bit-counter instance shares the stimulus.
module tb_prbs16_checker;
    logic        CLK = 1'b0;
    logic        rst, bit_in, bit_valid, clr_cnt;
    logic        locked, err_pulse, sync_lost;
    logic [15:0] err_count;
    logic        locked4, err_pulse4, sync_lost4;
    logic [3:0]  err_count4;
`ifdef PRBS_CHK_HEX_EN
    logic [6:0]  hex0, hex1, hex0_4, hex1_4;
`endif

    always #5 CLK = ~CLK;

    prbs16_checker dut (
        .CLK(CLK), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .sync_lost(sync_lost), .err_count(err_count)
`ifdef PRBS_CHK_HEX_EN
        , .HEX0(hex0), .HEX1(hex1)
`endif
    );

    prbs16_checker #(.ERR_W(4)) dut4 (
        .CLK(CLK), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clr_cnt(clr_cnt),
        .locked(locked4), .err_pulse(err_pulse4), .sync_lost(sync_lost4), .err_count(err_count4)
`ifdef PRBS_CHK_HEX_EN
        , .HEX0(hex0_4), .HEX1(hex1_4)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Scoreboard: the model pushes the expected output word for every clock, the sampler pops it.
    logic [25:0] exp_q[$];

    // Reference model state: the last 16 reference bits, oldest first.
    logic hist[$];
    logic m_locked, m_pulse, m_lost;
    int   m_fill, m_match, m_wpos, m_werr, m_cnt, m_cnt4;

    logic [15:0] gen;

    typedef struct {
        logic        flip;
        logic        valid;
        logic        clr;
        logic        exp_locked;
        logic        exp_pulse;
        logic [15:0] exp_cnt;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        hist = {};
        for (int i = 0; i < 16; i++) hist.push_back(1'b0);
        m_locked = 1'b0; m_pulse = 1'b0; m_lost = 1'b0;
        m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0; m_cnt = 0; m_cnt4 = 0;
        exp_q = {};
    endtask

    // Prediction: each bit is the XNOR of the bits 16, 15, 13 and 4 positions earlier.
    task automatic model_beat(input logic b, input logic v, input logic c);
        logic pred;
        int   ones;
        m_pulse = 1'b0;
        m_lost  = 1'b0;
        if (v) begin
            pred = ~(hist[0] ^ hist[1] ^ hist[3] ^ hist[12]);
            ones = 0;
            foreach (hist[i]) ones += int'(hist[i]);
            if (m_locked) begin
                hist.push_back(pred);
                void'(hist.pop_front());
                m_wpos++;
                if (b != pred) begin
                    m_pulse = 1'b1;
                    m_werr++;
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt4 < 15) m_cnt4++;
                end
                if (m_werr == 8) begin
                    m_locked = 1'b0; m_lost = 1'b1;
                    m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0;
                end else if (m_wpos == 64) begin
                    m_wpos = 0; m_werr = 0;
                end
            end else begin
                if (m_fill < 16) m_fill++;
                else if (b == pred && ones != 16) m_match++;
                else m_match = 0;
                hist.push_back(b);
                void'(hist.pop_front());
                if (m_match == 32) begin
                    m_locked = 1'b1;
                    m_match  = 0;
                end
            end
        end
        if (c) begin
            m_cnt  = 0;
            m_cnt4 = 0;
        end
        exp_q.push_back({m_locked, m_pulse, m_lost, 16'(m_cnt), m_locked, m_pulse, m_lost, 4'(m_cnt4)});
    endtask

    task automatic step(input logic b, input logic v, input logic c);
        logic [25:0] exp;
        bit_in = b; bit_valid = v; clr_cnt = c;
        @(posedge CLK);
        model_beat(b, v, c);
        #1;
        if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard: got empty queue expected one entry");
        end else begin
            exp = exp_q.pop_front();
            check("model", 32'({locked, err_pulse, sync_lost, err_count,
                                locked4, err_pulse4, sync_lost4, err_count4}), 32'(exp));
        end
    endtask

    task automatic gen_bit(output logic b);
        b   = ~(gen[15] ^ gen[14] ^ gen[12] ^ gen[3]);
        gen = {gen[14:0], b};
    endtask

    task automatic send(input logic flip, input logic v, input logic c);
        logic b;
        b = 1'($urandom);
        if (v) begin
            gen_bit(b);
            b = b ^ flip;
        end
        step(b, v, c);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 32'({locked, err_pulse, sync_lost, err_count, locked4, err_pulse4, sync_lost4, err_count4}), 32'd0);
`ifdef PRBS_CHK_HEX_EN
        check({name, "_hex"}, 32'({hex0, hex1, hex0_4, hex1_4}), 32'({7'h40, 7'h40, 7'h40, 7'h40}));
`endif
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear without a clock.
    task automatic do_reset(input string name);
        #2;
        rst = 1'b0; bit_valid = 1'b0; clr_cnt = 1'b0;
        #1;
        check_reset_outputs(name);
        model_reset();
        @(posedge CLK);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen_lock;
        int   rate;
        tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd8};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd9};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd9};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd9};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1};

        rst = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; clr_cnt = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_reset_outputs("power_on_reset");
        rst = 1'b1;

        // Clean lock from a generator seeded with zero.
        gen = 16'h0000;
        for (int n = 1; n <= 48; n++) begin
            send(1'b0, 1'b1, 1'b0);
            if (n == 47) check("lock_not_early", 32'(locked), 32'd0);
            if (n == 48) check("lock_at_48", 32'({locked, err_count}), 32'({1'b1, 16'd0}));
        end

        // Eight consecutive errors inside the first window force loss of sync.
        for (int k = 1; k <= 8; k++) begin
            send(1'b1, 1'b1, 1'b0);
            if (k == 7) check("locked_before_loss", 32'({locked, sync_lost}), 32'({1'b1, 1'b0}));
            if (k == 8) check("loss_on_8th", 32'({locked, err_pulse, sync_lost, err_count, err_count4}),
                              32'({1'b0, 1'b1, 1'b1, 16'd8, 4'd8}));
        end
        for (int n = 1; n <= 48; n++) begin
            send(1'b0, 1'b1, 1'b0);
            if (n == 1)  check("sync_lost_one_cycle", 32'(sync_lost), 32'd0);
            if (n == 47) check("relock_not_early", 32'(locked), 32'd0);
            if (n == 48) check("relock_at_48", 32'(locked), 32'd1);
        end

        // Single errors, a valid gap and clr_cnt colliding with an error.
        for (int i = 0; i < 7; i++) begin
            send(tbl[i].flip, tbl[i].valid, tbl[i].clr);
            check($sformatf("tbl%0d", i), 32'({locked, err_pulse, sync_lost, err_count}),
                  32'({tbl[i].exp_locked, tbl[i].exp_pulse, 1'b0, tbl[i].exp_cnt}));
        end

        // One error per 64 bits never loses lock; the 4-bit counter saturates.
        for (int e = 0; e < 20; e++) begin
            for (int j = 0; j < 63; j++) send(1'b0, 1'b1, 1'b0);
            send(1'b1, 1'b1, 1'b0);
        end
        check("sparse_errors_locked", 32'({locked, locked4}), 32'({1'b1, 1'b1}));
        check("count16_after_sparse", 32'(err_count), 32'd21);
        check("count4_saturated", 32'(err_count4), 32'd15);
`ifdef PRBS_CHK_HEX_EN
        check("hex_count_21", 32'({hex0, hex1}), 32'({7'h12, 7'h79}));
`endif
        send(1'b1, 1'b1, 1'b1);
        check("clr_beats_saturated_inc", 32'({err_pulse4, err_count4}), 32'({1'b1, 4'd0}));

        // Reset while locked, then an all-ones lockup stream.
        do_reset("midrun_reset");
        seen_lock = 1'b0;
        for (int n = 0; n < 200; n++) begin
            step(1'b1, 1'b1, 1'b0);
            seen_lock |= locked;
        end
        check("all_ones_never_locks", 32'(seen_lock), 32'd0);

        // Clean stream with bit_valid alternating: lock on the 48th valid bit.
        do_reset("reset_before_gaps");
        gen = 16'h0000;
        for (int i = 0; i < 96; i++) begin
            send(1'b0, (i % 2) == 0, 1'b0);
            if (i == 93) check("gapped_not_early", 32'(locked), 32'd0);
            if (i == 94) check("gapped_lock_48_valid", 32'(locked), 32'd1);
        end

        // Randomized traffic in segments of varying error rate.
        do_reset("reset_before_random");
        gen = 16'($urandom_range(0, 65534));
        for (int seg = 0; seg < 6; seg++) begin
            rate = (seg == 0) ? 0 : int'($urandom_range(0, 12));
            for (int n = 0; n < 500; n++) begin
                send($urandom_range(0, 99) < rate, $urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
